addsub_ascii_seq: RTL and testbench
===================================

# addsub_ascii_seq

Parametrised, sequential add/subtract unit with ASCII hex output. It latches two WIDTH-bit operands on a start pulse and evaluates the sum or difference one nibble per clock through a 4-bit ripple-carry stage. It then streams the result as ASCII hex characters, one per cycle, led by a carry/borrow character, and finally pulses ready. It sits between the operand/command front end and the UART/display character path, and replaces the single-nibble combinational adder.

## Interface
- WIDTH, 8, operand/result width in bits; multiple of 4, range 4..32
- DIGITS, WIDTH/4, derived localparam, not overridable; hex digit count
- clk  in  1  global clock, all logic on rising edge
- Gl_rst_n  in  1  reset, synchronous, active-low
- Gl_adder_start  in  1  start request; sampled only in IDLE
- Gl_subtract  in  1  1 = r1 - r2, 0 = r1 + r2; latched with start
- Gl_r1  in  WIDTH  operand 1; latched with start
- Gl_r2  in  WIDTH  operand 2; latched with start
- L2_busy  out  1  high in every state except IDLE
- L2_adder_data  out  8  ASCII character; valid only while L2_adder_valid
- L2_adder_valid  out  1  one character per cycle while high
- L2_adder_last  out  1  high with the final character
- L2_adder_rdy  out  1  one-cycle pulse after the final character
- L2_result  out  WIDTH  binary result, registered
- L2_carry  out  1  carry (add) or borrow (sub) = carry_out XOR Gl_subtract
- L2_ovf  out  1  two's-complement signed overflow

## Operation
- States: IDLE, CALC, EMIT, DONE.
- IDLE: start=1 latches r1, r2 and subtract. Working carry is initialised to subtract. Digit index is set to 0. Go to CALC.
- CALC, per cycle:
  - Compute nibble k = r1[4k+3:4k] + (r2[4k+3:4k] XOR {4{sub}}) + carry.
  - Write nibble k to the working register and update carry.
  - On k = DIGITS-1, also capture ovf = carry-into-bit-3 XOR carry-out-of-bit-3.
  - After DIGITS cycles: copy working register to L2_result, set L2_carry and L2_ovf, go to EMIT.
- EMIT: emit DIGITS+1 characters, one per cycle.
  - First character: '0' (0x30) or '1' (0x31) per L2_carry.
  - Then result nibbles, most significant first.
  - Nibble 0-9 maps to 0x30+n. Nibble 10-15 maps to 0x41+(n-10), uppercase.
  - L2_adder_last is high with the final character. Then go to DONE.
- DONE: L2_adder_rdy=1 for one cycle, then go to IDLE.
- Start while busy is ignored and not queued. Operand changes after the start edge have no effect.
- L2_result, L2_carry and L2_ovf hold their values until the next CALC->EMIT transition.
- Reset (Gl_rst_n=0 at an edge) wins over every other condition in every state:
  - State returns to IDLE.
  - All outputs go to 0, including L2_adder_data, L2_result and the flags.
  - A reset during EMIT truncates the stream with no last and no rdy.
- Start coincident with reset is dropped.

## Timing
- Start sampled at edge T.
- Busy is high from cycle T+1.
- CALC occupies cycles T+1..T+DIGITS.
- Valid is high in cycles T+DIGITS+1..T+2·DIGITS+1.
- rdy is high in cycle T+2·DIGITS+2.
- IDLE from cycle T+2·DIGITS+3; a new start is accepted at that cycle's edge.
- Start-to-rdy latency is 2·DIGITS+2 cycles. For WIDTH=8, rdy occurs at T+6.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- WIDTH=8, r1=0x3A, r2=0x25, sub=0: chars '0','5','F' at T+3..T+5, last at T+5, rdy at T+6; L2_result=0x5F, carry=0, ovf=0.
- WIDTH=8, 0x05-0x07: chars '1','F','E'; L2_result=0xFE, carry(borrow)=1, ovf=0.
- WIDTH=8, 0x7F+0x01: chars '0','8','0'; ovf=1, carry=0. Then 0xFF+0x01: chars '1','0','0'; L2_result=0x00, carry=1, ovf=0.
- WIDTH=8, second start at T+2 with different operands: ignored, first stream unchanged. Then Gl_rst_n=0 during EMIT: valid=0 and all outputs 0 on the next cycle, no rdy.
- WIDTH=16, 0x1234-0x1234: chars '0','0','0','0','0' at T+5..T+9, rdy at T+10, borrow=0, ovf=0.
- WIDTH=16, back-to-back: second start at T+11 accepted, rdy at T+21; L2_result holds the first result until T+15.

Source files
------------

// File: rtl/addsub_ascii_seq_if.sv
// addsub_ascii_seq_if
//   Operand/command and character-stream bundle for addsub_ascii_seq.
//   master : front end (drives start, subtract, operands; observes stream)
//   slave  : the add/subtract unit
//   Gl_adder_start  start request, sampled only while the unit is idle
//   Gl_subtract     1 = r1 - r2, 0 = r1 + r2
//   Gl_r1, Gl_r2    WIDTH-bit operands
//   L2_busy         high whenever the unit is not idle
//   L2_adder_data   ASCII character, qualified by L2_adder_valid
//   L2_adder_valid  one character per cycle while high
//   L2_adder_last   marks the final character
//   L2_adder_rdy    one-cycle pulse after the final character
//   L2_result       binary result
//   L2_carry        carry (add) or borrow (subtract)
//   L2_ovf          two's-complement overflow
interface addsub_ascii_seq_if #(
    parameter int WIDTH = 8
);
    logic             Gl_adder_start;
    logic             Gl_subtract;
    logic [WIDTH-1:0] Gl_r1;
    logic [WIDTH-1:0] Gl_r2;
    logic             L2_busy;
    logic [7:0]       L2_adder_data;
    logic             L2_adder_valid;
    logic             L2_adder_last;
    logic             L2_adder_rdy;
    logic [WIDTH-1:0] L2_result;
    logic             L2_carry;
    logic             L2_ovf;

    modport master (
        output Gl_adder_start, Gl_subtract, Gl_r1, Gl_r2,
        input  L2_busy, L2_adder_data, L2_adder_valid, L2_adder_last,
               L2_adder_rdy, L2_result, L2_carry, L2_ovf
    );

    modport slave (
        input  Gl_adder_start, Gl_subtract, Gl_r1, Gl_r2,
        output L2_busy, L2_adder_data, L2_adder_valid, L2_adder_last,
               L2_adder_rdy, L2_result, L2_carry, L2_ovf
    );
endinterface

// File: rtl/addsub_ascii_seq.sv
// addsub_ascii_seq
//   Sequential WIDTH-bit add/subtract: one nibble per clock through a 4-bit
//   ripple-carry stage, then the result is streamed as ASCII hex (carry/borrow
//   character first, then nibbles MSB first), followed by a ready pulse.
//   clk       rising-edge clock
//   Gl_rst_n  synchronous active-low reset; clears state and all outputs
//   bus       addsub_ascii_seq_if.slave (operands in, character stream out)
module addsub_ascii_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 Gl_rst_n,
    addsub_ascii_seq_if.slave    bus
);
    localparam int DIGITS = WIDTH / 4;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, acc_q, acc_d;
    logic             sub_q, sub_d, cy_q, cy_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             busy_q, busy_d, valid_q, valid_d, last_q, last_d;
    logic             rdy_q, rdy_d, carry_q, carry_d, ovf_q, ovf_d;
    logic [7:0]       data_q, data_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [3:0]       nib_a, nib_b;
    logic [4:0]       sum5;   // nibble sum with carry-out in bit 4
    logic [3:0]       low4;   // bits [2:0] sum; bit 3 is the carry into bit 3

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        sub_d    = sub_q;
        cy_d     = cy_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        rdy_d    = 1'b0;

        // Subtraction is r1 + ~r2 + 1; the +1 enters as the initial carry.
        nib_a = op1_q[4*idx_q +: 4];
        nib_b = op2_q[4*idx_q +: 4] ^ {4{sub_q}};
        sum5  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, cy_q};
        low4  = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, cy_q};

        case (state_q)
            IDLE: begin
                if (bus.Gl_adder_start) begin
                    op1_d   = bus.Gl_r1;
                    op2_d   = bus.Gl_r2;
                    sub_d   = bus.Gl_subtract;
                    cy_d    = bus.Gl_subtract;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d[4*idx_q +: 4] = sum5[3:0];
                cy_d  = sum5[4];
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Top nibble: publish the result and start the stream with
                    // the carry/borrow character in the same edge.
                    result_d = acc_d;
                    carry_d  = sum5[4] ^ sub_q;
                    ovf_d    = low4[3] ^ sum5[4];
                    data_d   = 8'h30 + {7'b0, carry_d};
                    valid_d  = 1'b1;
                    idx_d    = LAST_IDX;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (last_q) begin
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    data_d  = to_ascii(result_q[4*idx_q +: 4]);
                    valid_d = 1'b1;
                    last_d  = (idx_q == '0);
                    idx_d   = idx_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!Gl_rst_n) begin
            state_q  <= IDLE;
            // NOTE: operand and working registers are cleared as well; they
            // are few flops and this keeps every register free of X after reset.
            op1_q    <= '0;
            op2_q    <= '0;
            acc_q    <= '0;
            sub_q    <= 1'b0;
            cy_q     <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            rdy_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            acc_q    <= acc_d;
            sub_q    <= sub_d;
            cy_q     <= cy_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            rdy_q    <= rdy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.L2_busy        = busy_q;
    assign bus.L2_adder_data  = data_q;
    assign bus.L2_adder_valid = valid_q;
    assign bus.L2_adder_last  = last_q;
    assign bus.L2_adder_rdy   = rdy_q;
    assign bus.L2_result      = result_q;
    assign bus.L2_carry       = carry_q;
    assign bus.L2_ovf         = ovf_q;
endmodule

// File: tb/tb_addsub_ascii_seq.sv
// tb_addsub_ascii_seq
//   Directed bench for addsub_ascii_seq at WIDTH=8 and WIDTH=16. Inputs are
//   driven on the falling edge, outputs are sampled on the falling edge.
module tb_addsub_ascii_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    addsub_ascii_seq_if #(.WIDTH(8))  if8();
    addsub_ascii_seq_if #(.WIDTH(16)) if16();

    addsub_ascii_seq #(.WIDTH(8))  dut8  (.clk(clk), .Gl_rst_n(rst_n), .bus(if8.slave));
    addsub_ascii_seq #(.WIDTH(16)) dut16 (.clk(clk), .Gl_rst_n(rst_n), .bus(if16.slave));

    task automatic sample(input bit w16, output logic bsy, output logic [7:0] dat,
                          output logic vld, output logic lst, output logic rdy,
                          output logic [15:0] res, output logic cy, output logic ov);
        @(negedge clk);
        if (w16) begin
            bsy = if16.L2_busy;  dat = if16.L2_adder_data; vld = if16.L2_adder_valid;
            lst = if16.L2_adder_last; rdy = if16.L2_adder_rdy; res = if16.L2_result;
            cy = if16.L2_carry; ov = if16.L2_ovf;
        end else begin
            bsy = if8.L2_busy;  dat = if8.L2_adder_data; vld = if8.L2_adder_valid;
            lst = if8.L2_adder_last; rdy = if8.L2_adder_rdy; res = {8'h00, if8.L2_result};
            cy = if8.L2_carry; ov = if8.L2_ovf;
        end
    endtask

    task automatic set_inputs(input bit w16, input logic st, input logic [15:0] a,
                              input logic [15:0] b, input logic s);
        if (w16) begin
            if16.Gl_adder_start = st; if16.Gl_r1 = a; if16.Gl_r2 = b; if16.Gl_subtract = s;
        end else begin
            if8.Gl_adder_start = st; if8.Gl_r1 = a[7:0]; if8.Gl_r2 = b[7:0]; if8.Gl_subtract = s;
        end
    endtask

    // Start is sampled at edge T; returns 1 ns after T with operands scrambled.
    task automatic drive_start(input bit w16, input logic [15:0] a, input logic [15:0] b,
                               input logic s);
        @(negedge clk);
        set_inputs(w16, 1'b1, a, b, s);
        @(posedge clk);
        #1;
        set_inputs(w16, 1'b0, ~a, a ^ b, ~s);
    endtask

    task automatic test_reset();
        logic bsy, vld, lst, rdy, cy, ov;
        logic [7:0] dat;
        logic [15:0] res;
        rst_n = 1'b0;
        set_inputs(1'b0, 1'b1, 16'h0033, 16'h0011, 1'b0);
        set_inputs(1'b1, 1'b1, 16'h3333, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w[0], bsy, dat, vld, lst, rdy, res, cy, ov);
            tests++;
            if ({bsy, dat, vld, lst, rdy, res, cy, ov} !== 30'd0) begin
                fails++;
                $display("FAIL reset_state w16=%0d got %h expected 0", w,
                         {bsy, dat, vld, lst, rdy, res, cy, ov});
            end
        end
        rst_n = 1'b1;
        set_inputs(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_inputs(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int w = 0; w < 2; w++) begin
            sample(w[0], bsy, dat, vld, lst, rdy, res, cy, ov);
            tests++;
            if (bsy !== 1'b0) begin
                fails++;
                $display("FAIL start_with_reset w16=%0d busy got %b expected 0", w, bsy);
            end
        end
    endtask

    // ec holds up to five expected characters, first character leftmost.
    task automatic test_vector(input string name, input bit w16, input logic [15:0] a,
                               input logic [15:0] b, input logic s, input logic [4:0][7:0] ec,
                               input logic [15:0] er, input logic ecy, input logic eov);
        logic bsy, vld, lst, rdy, cy, ov;
        logic [7:0] dat;
        logic [15:0] res;
        int d;
        d = w16 ? 4 : 2;
        drive_start(w16, a, b, s);
        for (int k = 1; k <= 2*d + 3; k++) begin
            sample(w16, bsy, dat, vld, lst, rdy, res, cy, ov);
            tests++;
            if (bsy !== 1'(k <= 2*d + 2)) begin
                fails++; $display("FAIL %s busy k=%0d got %b", name, k, bsy);
            end
            tests++;
            if (vld !== 1'(k >= d + 1 && k <= 2*d + 1)) begin
                fails++; $display("FAIL %s valid k=%0d got %b", name, k, vld);
            end
            tests++;
            if (lst !== 1'(k == 2*d + 1)) begin
                fails++; $display("FAIL %s last k=%0d got %b", name, k, lst);
            end
            tests++;
            if (rdy !== 1'(k == 2*d + 2)) begin
                fails++; $display("FAIL %s rdy k=%0d got %b", name, k, rdy);
            end
            if (k >= d + 1 && k <= 2*d + 1) begin
                tests++;
                if (dat !== ec[4 - (k - d - 1)]) begin
                    fails++;
                    $display("FAIL %s char k=%0d got %h expected %h", name, k, dat, ec[4 - (k - d - 1)]);
                end
            end
            if (k == 2*d + 2) begin
                tests++;
                if ({res, cy, ov} !== {er, ecy, eov}) begin
                    fails++;
                    $display("FAIL %s result got %h/%b/%b expected %h/%b/%b",
                             name, res, cy, ov, er, ecy, eov);
                end
            end
        end
    endtask

    // Second start at T+2 is ignored; the first stream completes unchanged.
    task automatic test_busy_ignore();
        logic bsy, vld, lst, rdy, cy, ov;
        logic [7:0] dat;
        logic [15:0] res;
        logic [2:0][7:0] ec;
        ec = {8'h30, 8'h35, 8'h46};
        drive_start(1'b0, 16'h003A, 16'h0025, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            sample(1'b0, bsy, dat, vld, lst, rdy, res, cy, ov);
            if (k == 2) set_inputs(1'b0, 1'b1, 16'h0011, 16'h0022, 1'b1);
            if (k == 3) set_inputs(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            tests++;
            if ({bsy, vld, lst, rdy} !== {1'(k <= 6), 1'(k >= 3 && k <= 5), 1'(k == 5), 1'(k == 6)}) begin
                fails++;
                $display("FAIL busy_ignore ctrl k=%0d got %b%b%b%b", k, bsy, vld, lst, rdy);
            end
            if (k >= 3 && k <= 5) begin
                tests++;
                if (dat !== ec[2 - (k - 3)]) begin
                    fails++;
                    $display("FAIL busy_ignore char k=%0d got %h expected %h", k, dat, ec[2 - (k - 3)]);
                end
            end
            if (k == 6) begin
                tests++;
                if ({res, cy, ov} !== {16'h005F, 1'b0, 1'b0}) begin
                    fails++;
                    $display("FAIL busy_ignore result got %h/%b/%b expected 005f/0/0", res, cy, ov);
                end
            end
        end
    endtask

    // Reset asserted during EMIT truncates the stream with no last and no rdy.
    task automatic test_reset_emit();
        logic bsy, vld, lst, rdy, cy, ov;
        logic [7:0] dat;
        logic [15:0] res;
        drive_start(1'b0, 16'h007F, 16'h0001, 1'b0);
        for (int k = 1; k <= 4; k++) sample(1'b0, bsy, dat, vld, lst, rdy, res, cy, ov);
        tests++;
        if ({vld, lst, dat} !== {1'b1, 1'b0, 8'h38}) begin
            fails++;
            $display("FAIL reset_emit pre got v=%b l=%b d=%h expected 1/0/38", vld, lst, dat);
        end
        rst_n = 1'b0;
        sample(1'b0, bsy, dat, vld, lst, rdy, res, cy, ov);
        tests++;
        if ({bsy, dat, vld, lst, rdy, res, cy, ov} !== 30'd0) begin
            fails++;
            $display("FAIL reset_emit cleared got %h expected 0", {bsy, dat, vld, lst, rdy, res, cy, ov});
        end
        rst_n = 1'b1;
        for (int k = 6; k <= 8; k++) begin
            sample(1'b0, bsy, dat, vld, lst, rdy, res, cy, ov);
            tests++;
            if ({bsy, vld, lst, rdy} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_emit after k=%0d got %b%b%b%b expected 0000", k, bsy, vld, lst, rdy);
            end
        end
    endtask

    // WIDTH=16: 0xABCD+0x1234 then 0x1234-0x1234 started at T+11.
    task automatic test_back_to_back();
        logic bsy, vld, lst, rdy, cy, ov;
        logic [7:0] dat;
        logic [15:0] res;
        logic [4:0][7:0] ec1;
        logic exp_v;
        ec1 = {8'h30, 8'h42, 8'h45, 8'h30, 8'h31};
        drive_start(1'b1, 16'hABCD, 16'h1234, 1'b0);
        for (int k = 1; k <= 23; k++) begin
            sample(1'b1, bsy, dat, vld, lst, rdy, res, cy, ov);
            if (k == 11) set_inputs(1'b1, 1'b1, 16'h1234, 16'h1234, 1'b1);
            if (k == 12) set_inputs(1'b1, 1'b0, 16'hFFFF, 16'h0F0F, 1'b0);
            exp_v = 1'((k >= 5 && k <= 9) || (k >= 16 && k <= 20));
            tests++;
            if ({bsy, vld, lst, rdy} !== {1'(k <= 10 || (k >= 12 && k <= 21)), exp_v,
                                          1'(k == 9 || k == 20), 1'(k == 10 || k == 21)}) begin
                fails++;
                $display("FAIL back_to_back ctrl k=%0d got %b%b%b%b", k, bsy, vld, lst, rdy);
            end
            if (k >= 5 && k <= 9) begin
                tests++;
                if (dat !== ec1[4 - (k - 5)]) begin
                    fails++;
                    $display("FAIL back_to_back char1 k=%0d got %h expected %h", k, dat, ec1[4 - (k - 5)]);
                end
            end
            if (k >= 16 && k <= 20) begin
                tests++;
                if (dat !== 8'h30) begin
                    fails++;
                    $display("FAIL back_to_back char2 k=%0d got %h expected 30", k, dat);
                end
            end
            if (k == 10 || k == 15) begin
                tests++;
                if ({res, cy, ov} !== {16'hBE01, 1'b0, 1'b0}) begin
                    fails++;
                    $display("FAIL back_to_back result1 k=%0d got %h/%b/%b expected be01/0/0", k, res, cy, ov);
                end
            end
            if (k == 16 || k == 21) begin
                tests++;
                if ({res, cy, ov} !== {16'h0000, 1'b0, 1'b0}) begin
                    fails++;
                    $display("FAIL back_to_back result2 k=%0d got %h/%b/%b expected 0000/0/0", k, res, cy, ov);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_inputs(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_inputs(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        test_reset();
        test_vector("add_3a_25", 1'b0, 16'h003A, 16'h0025, 1'b0,
                    {8'h30, 8'h35, 8'h46, 8'h00, 8'h00}, 16'h005F, 1'b0, 1'b0);
        test_vector("sub_05_07", 1'b0, 16'h0005, 16'h0007, 1'b1,
                    {8'h31, 8'h46, 8'h45, 8'h00, 8'h00}, 16'h00FE, 1'b1, 1'b0);
        test_vector("add_7f_01", 1'b0, 16'h007F, 16'h0001, 1'b0,
                    {8'h30, 8'h38, 8'h30, 8'h00, 8'h00}, 16'h0080, 1'b0, 1'b1);
        test_vector("add_ff_01", 1'b0, 16'h00FF, 16'h0001, 1'b0,
                    {8'h31, 8'h30, 8'h30, 8'h00, 8'h00}, 16'h0000, 1'b1, 1'b0);
        test_vector("sub_80_01", 1'b0, 16'h0080, 16'h0001, 1'b1,
                    {8'h30, 8'h37, 8'h46, 8'h00, 8'h00}, 16'h007F, 1'b0, 1'b1);
        test_busy_ignore();
        test_reset_emit();
        test_vector("sub_1234_1234", 1'b1, 16'h1234, 16'h1234, 1'b1,
                    {8'h30, 8'h30, 8'h30, 8'h30, 8'h30}, 16'h0000, 1'b0, 1'b0);
        test_vector("sub_8000_0001", 1'b1, 16'h8000, 16'h0001, 1'b1,
                    {8'h30, 8'h37, 8'h46, 8'h46, 8'h46}, 16'h7FFF, 1'b0, 1'b1);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
